i2c_write_arbiter: RTL and testbench

Shares the single I2C_Controller write engine between N_REQ requesters, for example the codec power-on configuration sequencer and a runtime volume/mute controller. It grants the bus round-robin and drives the controller's GO/WDATA handshake. It retries NACKed transfers up to MAX_RETRY times and watchdogs stalled transfers. Each requester gets a one-cycle done or error pulse.

---
 rtl/i2c_write_arbiter_pkg.sv | 16 +
 rtl/i2c_write_arbiter_rr.sv | 48 ++++
 rtl/i2c_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_i2c_write_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_write_arbiter_pkg.sv
// Shared types and constants for the I2C write arbiter.
// Holds the FSM state encoding and the codec word layout.
package i2c_write_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_START,
    ST_WAIT_END,
    ST_RELEASE
  } arb_state_e;

  localparam int I2C_WORD_W = 24;
  localparam logic [7:0] CODEC_SLAVE_ADDR = 8'h34;

endpackage

// File: rtl/i2c_write_arbiter_rr.sv
// Round-robin request picker with a registered start pointer.
// The pointer moves to one past the last owner when adv is high.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  input  logic [PW-1:0] last_idx,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_q) + i) % N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = PW'(k);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = (last_idx == PW'(N - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/i2c_write_arbiter.sv
// Shares one I2C write engine between N_REQ requesters, round-robin,
// with NACK retry and a per-attempt tick watchdog.
module i2c_write_arbiter
  import i2c_write_arbiter_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int DATA_W        = I2C_WORD_W,
  parameter int MAX_RETRY     = 3,
  parameter int TIMEOUT_TICKS = 1023
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iTICK,
  input  logic [N_REQ-1:0]        iREQ,
  input  logic [N_REQ*DATA_W-1:0] iWDATA,
  output logic [N_REQ-1:0]        oDONE,
  output logic [N_REQ-1:0]        oERR,
  output logic [N_REQ-1:0]        oGRANT,
  output logic                    oBUSY,
  output logic                    oI2C_GO,
  output logic [DATA_W-1:0]       oI2C_WDATA,
  input  logic                    iI2C_END,
  input  logic                    iI2C_ACK
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_TICKS);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              go_q, go_d;
  logic              busy_q, busy_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic [N_REQ-1:0]  arb_grant;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;
  logic              arb_adv;
  logic [TW-1:0]     tmo_inc;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk      (iCLK),
    .rst      (iRST),
    .req      (iREQ),
    .adv      (arb_adv),
    .last_idx (owner_q),
    .grant    (arb_grant),
    .idx      (arb_idx),
    .any      (arb_any)
  );

  assign tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    wdata_d = wdata_q;
    go_d    = go_q;
    busy_d  = busy_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    done_d  = '0;
    err_d   = '0;
    arb_adv = 1'b0;
    if (iTICK) begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_d = arb_grant;
            owner_d = arb_idx;
            wdata_d = iWDATA[arb_idx*DATA_W +: DATA_W];
            retry_d = '0;
            tmo_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          go_d    = 1'b1;
          tmo_d   = '0;
          state_d = ST_WAIT_START;
        end
        ST_WAIT_START: begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIM) begin
            go_d    = 1'b0;
            err_d   = grant_q;
            state_d = ST_RELEASE;
          end else if (!iI2C_END) begin
            state_d = ST_WAIT_END;
          end
        end
        ST_WAIT_END: begin
          // Completion wins over a watchdog expiry on the same tick
          if (iI2C_END) begin
            go_d = 1'b0;
            if (!iI2C_ACK) begin
              done_d  = grant_q;
              state_d = ST_RELEASE;
            end else if (retry_q < RETRY_LIM) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_LAUNCH;
            end else begin
              err_d   = grant_q;
              state_d = ST_RELEASE;
            end
          end else if (tmo_inc == TMO_LIM) begin
            go_d    = 1'b0;
            err_d   = grant_q;
            state_d = ST_RELEASE;
          end else begin
            tmo_d = tmo_inc;
          end
        end
        ST_RELEASE: begin
          grant_d = '0;
          busy_d  = 1'b0;
          arb_adv = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      wdata_q <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      wdata_q <= wdata_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
    end
  end

  assign oDONE      = done_q;
  assign oERR       = err_q;
  assign oGRANT     = grant_q;
  assign oBUSY      = busy_q;
  assign oI2C_GO    = go_q;
  assign oI2C_WDATA = wdata_q;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Directed bench for i2c_write_arbiter with a small I2C controller
// model whose NACK count and hang behaviour are set per test.
module tb_i2c_write_arbiter;
  import i2c_write_arbiter_pkg::*;

  localparam logic [23:0] W_A = {CODEC_SLAVE_ADDR, 8'h1E, 8'h00};
  localparam logic [23:0] W_B = 24'h340A17;
  localparam logic [23:0] W_C = 24'h340C55;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iTICK = 1'b0;
  logic [1:0]  iREQ = '0;
  logic [47:0] iWDATA = '0;
  logic [1:0]  oDONE, oERR, oGRANT;
  logic        oBUSY, oI2C_GO;
  logic [23:0] oI2C_WDATA;
  logic        iI2C_END, iI2C_ACK;

  i2c_write_arbiter #(
    .N_REQ(2), .DATA_W(24), .MAX_RETRY(3), .TIMEOUT_TICKS(1023)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iTICK(iTICK), .iREQ(iREQ),
    .iWDATA(iWDATA), .oDONE(oDONE), .oERR(oERR), .oGRANT(oGRANT),
    .oBUSY(oBUSY), .oI2C_GO(oI2C_GO), .oI2C_WDATA(oI2C_WDATA),
    .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK)
  );

  always #5 iCLK = ~iCLK;

  int tick_mode = 0;
  int tcnt = 0;
  always @(negedge iCLK) begin
    tcnt = tcnt + 1;
    case (tick_mode)
      0: iTICK = 1'b1;
      1: iTICK = (tcnt % 3 == 0);
      default: iTICK = 1'b0;
    endcase
  end

  int nack_target = 0;
  bit hang = 1'b0;
  int base = 0;
  int m_launches = 0;
  int m_att = 0;
  int m_cnt = 0;
  bit m_busy = 1'b0;
  bit m_launched = 1'b0;
  logic m_end = 1'b1;
  logic m_ack = 1'b0;
  assign iI2C_END = m_end;
  assign iI2C_ACK = m_ack;

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      m_end <= 1'b1;
      m_ack <= 1'b0;
      m_busy <= 1'b0;
      m_launched <= 1'b0;
      m_cnt <= 0;
    end else if (iTICK) begin
      if (!oI2C_GO) m_launched <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          m_end <= 1'b1;
          m_busy <= 1'b0;
          m_ack <= (m_att <= nack_target);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (oI2C_GO && !m_launched && !hang) begin
        m_launched <= 1'b1;
        m_busy <= 1'b1;
        m_end <= 1'b0;
        m_cnt <= 3;
        m_launches <= m_launches + 1;
        m_att <= m_launches + 1 - base;
      end
    end
  end

  int go_rises = 0;
  logic go_prev = 1'b0;
  always @(posedge iCLK) begin
    go_prev <= oI2C_GO;
    if (oI2C_GO && !go_prev) go_rises <= go_rises + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_pulse(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge iCLK);
      if ((oDONE | oERR) != 2'b00) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no pulse expected done/err in 3000 cycles", nm);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [23:0] w0;
    logic [23:0] w1;
    int          nacks;
    logic [1:0]  exp_done;
    logic [1:0]  exp_err;
    logic [1:0]  exp_grant;
    logic [23:0] exp_wdata;
    int          exp_go;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit ok;
    int go0;
    int cnt;
    string nm;

    tbl[0] = '{2'b01, W_A, W_C, 0,  2'b01, 2'b00, 2'b01, W_A, 1};
    tbl[1] = '{2'b11, W_B, W_C, 0,  2'b10, 2'b00, 2'b10, W_C, 1};
    tbl[2] = '{2'b11, W_B, W_C, 0,  2'b01, 2'b00, 2'b01, W_B, 1};
    tbl[3] = '{2'b11, W_A, W_B, 0,  2'b10, 2'b00, 2'b10, W_B, 1};
    tbl[4] = '{2'b11, W_A, W_B, 0,  2'b01, 2'b00, 2'b01, W_A, 1};
    tbl[5] = '{2'b10, W_A, W_C, 2,  2'b10, 2'b00, 2'b10, W_C, 3};
    tbl[6] = '{2'b01, W_B, W_C, 99, 2'b00, 2'b01, 2'b01, W_B, 4};
    tbl[7] = '{2'b11, W_A, W_C, 99, 2'b00, 2'b10, 2'b10, W_C, 4};
    tbl[8] = '{2'b10, W_B, W_A, 0,  2'b10, 2'b00, 2'b10, W_A, 1};
    tbl[9] = '{2'b11, W_C, W_B, 3,  2'b01, 2'b00, 2'b01, W_C, 4};

    repeat (2) @(negedge iCLK);
    chk("rst_grant", oGRANT, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_go", oI2C_GO, 0);
    chk("rst_wdata", oI2C_WDATA, 0);
    chk("rst_pulse", oDONE | oERR, 0);
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("idle_busy", oBUSY, 0);

    for (int v = 0; v < 10; v++) begin
      iWDATA = {tbl[v].w1, tbl[v].w0};
      nack_target = tbl[v].nacks;
      base = m_launches;
      go0 = go_rises;
      iREQ = tbl[v].req;
      nm = $sformatf("vec%0d", v);
      wait_pulse(nm, ok);
      if (ok) begin
        chk({nm, "_done"}, oDONE, tbl[v].exp_done);
        chk({nm, "_err"}, oERR, tbl[v].exp_err);
        chk({nm, "_grant"}, oGRANT, tbl[v].exp_grant);
        chk({nm, "_wdata"}, oI2C_WDATA, tbl[v].exp_wdata);
        chk({nm, "_go_low"}, oI2C_GO, 0);
        chk({nm, "_launches"}, go_rises - go0, tbl[v].exp_go);
        iREQ = iREQ & ~(oDONE | oERR);
        @(negedge iCLK);
        chk({nm, "_pulse_1cyc"}, oDONE | oERR, 0);
        chk({nm, "_released"}, {oGRANT, oBUSY}, 0);
      end
    end

    nack_target = 0;
    tick_mode = 2;
    iWDATA = {W_B, W_A};
    iREQ = 2'b01;
    repeat (6) @(negedge iCLK);
    chk("notick_busy", oBUSY, 0);
    chk("notick_grant", oGRANT, 0);
    tick_mode = 1;
    wait_pulse("slow_tick", ok);
    if (ok) begin
      chk("slow_done", oDONE, 2'b01);
      chk("slow_wdata", oI2C_WDATA, W_A);
      iREQ = 2'b00;
      @(negedge iCLK);
      chk("slow_pulse_1cyc", oDONE, 0);
    end
    iREQ = 2'b00;
    tick_mode = 0;
    repeat (4) @(negedge iCLK);

    hang = 1'b1;
    go0 = go_rises;
    iREQ = 2'b01;
    cnt = 0;
    while (!oI2C_GO && cnt < 20) begin
      @(negedge iCLK);
      cnt++;
    end
    chk("tmo_go_seen", oI2C_GO, 1);
    cnt = 0;
    while ((oERR | oDONE) == 2'b00 && cnt < 2000) begin
      @(negedge iCLK);
      cnt++;
    end
    chk("tmo_ticks", cnt, 1023);
    chk("tmo_err", oERR, 2'b01);
    chk("tmo_done", oDONE, 0);
    chk("tmo_go_low", oI2C_GO, 0);
    chk("tmo_no_retry", go_rises - go0, 1);
    iREQ = 2'b00;
    @(negedge iCLK);
    chk("tmo_idle", oBUSY, 0);
    hang = 1'b0;
    repeat (3) @(negedge iCLK);

    iWDATA = {W_C, W_B};
    iREQ = 2'b10;
    cnt = 0;
    while (!(oBUSY && !iI2C_END) && cnt < 50) begin
      @(negedge iCLK);
      cnt++;
    end
    @(negedge iCLK);
    chk("mid_busy", oBUSY, 1);
    chk("mid_go", oI2C_GO, 1);
    #2 iRST = 1'b1;
    #1;
    chk("arst_go", oI2C_GO, 0);
    chk("arst_grant", oGRANT, 0);
    chk("arst_busy", oBUSY, 0);
    repeat (2) @(negedge iCLK);
    iREQ = 2'b11;
    iRST = 1'b0;
    wait_pulse("post_rst_a", ok);
    if (ok) begin
      chk("post_rst_a_done", oDONE, 2'b01);
      chk("post_rst_a_wdata", oI2C_WDATA, W_B);
      iREQ = iREQ & ~oDONE;
    end
    wait_pulse("post_rst_b", ok);
    if (ok) begin
      chk("post_rst_b_done", oDONE, 2'b10);
      chk("post_rst_b_wdata", oI2C_WDATA, W_C);
    end
    iREQ = 2'b00;
    repeat (3) @(negedge iCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
